// File: rtl/fetch_seq_ctrl_pkg.sv
// rtl/fetch_seq_ctrl_pkg.sv - shared frontend types and constants for the fetch sequencer
package fetch_seq_ctrl_pkg;

    localparam int VLEN                    = 32;
    localparam int FETCH_WIDTH             = 32;
    localparam int FETCH_BYTES             = FETCH_WIDTH / 8;
    localparam int FETCH_OFFS              = $clog2(FETCH_BYTES);
    localparam int DEFAULT_MAX_OUTSTANDING = 2;

    typedef struct packed {
        logic [VLEN-1:0]        addr;
        logic [FETCH_WIDTH-1:0] data;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        STALL
    } fetch_seq_state_e;

    function automatic logic [VLEN-1:0] align_block(input logic [VLEN-1:0] addr);
        return {addr[VLEN-1:FETCH_OFFS], {FETCH_OFFS{1'b0}}};
    endfunction

endpackage

// File: rtl/fetch_seq_ctrl_if.sv
// rtl/fetch_seq_ctrl_if.sv - redirect, I$ and realigner signal bundle of the fetch sequencer
interface fetch_seq_ctrl_if;
    import fetch_seq_ctrl_pkg::*;

    logic                   redirect_valid_i;
    logic [VLEN-1:0]        redirect_addr_i;
    logic                   icache_req_o;
    logic [VLEN-1:0]        icache_addr_o;
    logic                   icache_gnt_i;
    logic                   icache_rvalid_i;
    logic [FETCH_WIDTH-1:0] icache_rdata_i;
    logic                   icache_kill_o;
    logic                   realign_valid_o;
    logic [VLEN-1:0]        realign_addr_o;
    logic [FETCH_WIDTH-1:0] realign_data_o;
    logic                   realign_flush_o;
    logic                   serving_unaligned_i;
    logic                   queue_ready_i;
    logic                   busy_o;

    modport master (
        input  redirect_valid_i, redirect_addr_i, icache_gnt_i, icache_rvalid_i,
               icache_rdata_i, serving_unaligned_i, queue_ready_i,
        output icache_req_o, icache_addr_o, icache_kill_o, realign_valid_o,
               realign_addr_o, realign_data_o, realign_flush_o, busy_o
    );

    modport slave (
        output redirect_valid_i, redirect_addr_i, icache_gnt_i, icache_rvalid_i,
               icache_rdata_i, serving_unaligned_i, queue_ready_i,
        input  icache_req_o, icache_addr_o, icache_kill_o, realign_valid_o,
               realign_addr_o, realign_data_o, realign_flush_o, busy_o
    );

endinterface

// File: rtl/fetch_seq_ctrl_resp_fifo.sv
// rtl/fetch_seq_ctrl_resp_fifo.sv - in-order response buffer of fetch blocks with flush clear
module fetch_resp_fifo
    import fetch_seq_ctrl_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;

    // Explicit wrap keeps DEPTH == 1 correct with a 1-bit pointer.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !clear) mem[wr_ptr] <= push_entry;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;

    push_full_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && full && !pop && !clear));
    pop_empty_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop && empty && !clear));

endmodule

// File: rtl/fetch_seq_ctrl.sv
// rtl/fetch_seq_ctrl.sv - fetch-block request sequencer between PC-gen, I$ and instr_realign
module fetch_seq_ctrl
    import fetch_seq_ctrl_pkg::*;
#(
    parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    fetch_seq_ctrl_if.master bus
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    fetch_seq_state_e state_q, state_d;
    logic [VLEN-1:0]  fetch_addr_q;
    logic [VLEN-1:0]  resp_addr_q;
    logic [CNT_W-1:0] outstanding_q;
    logic [CNT_W-1:0] kill_cnt_q;

    logic             redirect, req, req_gnt, push, pop, rvalid;
    logic             empty, full;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   outstanding_d, kill_cnt_d, count_d, total_d, kill_sum;
    fetch_entry_t     head, push_entry;

    always_comb begin
        redirect = bus.redirect_valid_i;
        rvalid   = bus.icache_rvalid_i;
        req      = (state_q == FETCH) && !redirect;
        req_gnt  = req && bus.icache_gnt_i;
        push     = rvalid && (kill_cnt_q == '0) && !redirect;
        pop      = !empty && bus.queue_ready_i && !bus.serving_unaligned_i && !redirect;

        push_entry.addr = resp_addr_q;
        push_entry.data = bus.icache_rdata_i;

        kill_sum = {1'b0, kill_cnt_q} + {1'b0, outstanding_q} + (CNT_W+1)'(req_gnt);
        if (redirect) begin
            // Everything still in flight must be dropped, including a response landing now.
            outstanding_d = '0;
            kill_cnt_d    = kill_sum - (CNT_W+1)'(rvalid && (kill_sum != '0));
            count_d       = '0;
        end else begin
            outstanding_d = {1'b0, outstanding_q} + (CNT_W+1)'(req_gnt) - (CNT_W+1)'(push);
            kill_cnt_d    = {1'b0, kill_cnt_q} - (CNT_W+1)'(rvalid && (kill_cnt_q != '0));
            count_d       = {1'b0, count} + (CNT_W+1)'(push) - (CNT_W+1)'(pop);
        end
        total_d = outstanding_d + count_d;

        state_d = state_q;
        if (redirect) begin
            state_d = FETCH;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                FETCH,
                STALL:   state_d = (total_d >= (CNT_W+1)'(MAX_OUTSTANDING)) ? STALL : FETCH;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            fetch_addr_q  <= '0;
            resp_addr_q   <= '0;
            outstanding_q <= '0;
            kill_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d[CNT_W-1:0];
            kill_cnt_q    <= kill_cnt_d[CNT_W-1:0];
            if (redirect) begin
                fetch_addr_q <= bus.redirect_addr_i;
                resp_addr_q  <= bus.redirect_addr_i;
            end else begin
                if (req_gnt) fetch_addr_q <= align_block(fetch_addr_q) + VLEN'(FETCH_BYTES);
                // The first block after a redirect keeps the full target; later ones are aligned.
                if (push)    resp_addr_q  <= align_block(resp_addr_q) + VLEN'(FETCH_BYTES);
            end
        end
    end

    fetch_resp_fifo #(.DEPTH(MAX_OUTSTANDING)) u_resp_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear      (redirect),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .empty      (empty),
        .full       (full),
        .count      (count)
    );

    assign bus.icache_req_o    = req;
    assign bus.icache_addr_o   = align_block(fetch_addr_q);
    assign bus.icache_kill_o   = redirect;
    assign bus.realign_flush_o = redirect;
    assign bus.realign_valid_o = !empty;
    assign bus.realign_addr_o  = empty ? '0 : head.addr;
    assign bus.realign_data_o  = empty ? '0 : head.data;
    assign bus.busy_o          = (outstanding_q != '0) || !empty;

    rvalid_expected_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rvalid |-> (outstanding_q != '0 || kill_cnt_q != '0));
    outstanding_range_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        outstanding_d <= (CNT_W+1)'(MAX_OUTSTANDING));
    kill_range_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        kill_cnt_d <= (CNT_W+1)'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// tb/tb_fetch_seq_ctrl.sv - directed vector bench for fetch_seq_ctrl
module tb_fetch_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fetch_seq_ctrl_if bus ();

    fetch_seq_ctrl #(.MAX_OUTSTANDING(2)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic        rd;
        logic [31:0] ra;
        logic        gnt;
        logic        rv;
        logic [31:0] d;
        logic        su;
        logic        qr;
        logic        e_req;
        logic [31:0] e_ia;
        logic        e_kill;
        logic        e_rv;
        logic [31:0] e_ra;
        logic [31:0] e_d;
        logic        e_busy;
    } vec_t;

    localparam logic [31:0] D0 = 32'hD000_0000, D1 = 32'hD000_0011, D2 = 32'hD000_0022;
    localparam logic [31:0] D3 = 32'hD000_0033, D4 = 32'hD000_0044, D5 = 32'hD000_0055;

    vec_t vecs [21];

    function automatic vec_t mk(logic rd, logic [31:0] ra, logic gnt, logic rv, logic [31:0] d,
                                logic su, logic qr, logic e_req, logic [31:0] e_ia, logic e_kill,
                                logic e_rv, logic [31:0] e_ra, logic [31:0] e_d, logic e_busy);
        vec_t v;
        v.rd = rd; v.ra = ra; v.gnt = gnt; v.rv = rv; v.d = d; v.su = su; v.qr = qr;
        v.e_req = e_req; v.e_ia = e_ia; v.e_kill = e_kill; v.e_rv = e_rv;
        v.e_ra = e_ra; v.e_d = e_d; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic [31:0] ra, input logic gnt, input logic rv,
                         input logic [31:0] d, input logic su, input logic qr);
        bus.redirect_valid_i    = rd;
        bus.redirect_addr_i     = ra;
        bus.icache_gnt_i        = gnt;
        bus.icache_rvalid_i     = rv;
        bus.icache_rdata_i      = d;
        bus.serving_unaligned_i = su;
        bus.queue_ready_i       = qr;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic req, input logic [31:0] ia,
                             input logic kill, input logic rv, input logic [31:0] ra,
                             input logic [31:0] d, input logic busy);
        check({tag, " req"},   bus.icache_req_o,    req);
        check({tag, " iaddr"}, bus.icache_addr_o,   ia);
        check({tag, " kill"},  bus.icache_kill_o,   kill);
        check({tag, " flush"}, bus.realign_flush_o, kill);
        check({tag, " rv"},    bus.realign_valid_o, rv);
        check({tag, " raddr"}, bus.realign_addr_o,  ra);
        check({tag, " rdata"}, bus.realign_data_o,  d);
        check({tag, " busy"},  bus.busy_o,          busy);
    endtask

    initial begin
        // rd  ra            gnt rv d   su qr | req ia            k  rv ra            d   busy
        vecs[0]  = mk(0, 0,            0, 0, 0,  0, 0,  0, 0,            0, 0, 0,            0,  0);
        vecs[1]  = mk(1, 32'h8000_0000, 0, 0, 0,  0, 0,  0, 0,            1, 0, 0,            0,  0);
        vecs[2]  = mk(0, 0,            1, 0, 0,  0, 0,  1, 32'h8000_0000, 0, 0, 0,            0,  0);
        vecs[3]  = mk(0, 0,            1, 1, D0, 0, 1,  1, 32'h8000_0004, 0, 0, 0,            0,  1);
        vecs[4]  = mk(0, 0,            1, 1, D1, 0, 1,  0, 32'h8000_0008, 0, 1, 32'h8000_0000, D0, 1);
        vecs[5]  = mk(0, 0,            1, 0, 0,  0, 1,  1, 32'h8000_0008, 0, 1, 32'h8000_0004, D1, 1);
        vecs[6]  = mk(0, 0,            1, 1, D2, 0, 1,  1, 32'h8000_000C, 0, 0, 0,            0,  1);
        vecs[7]  = mk(0, 0,            0, 1, D3, 0, 1,  0, 32'h8000_0010, 0, 1, 32'h8000_0008, D2, 1);
        vecs[8]  = mk(0, 0,            0, 0, 0,  0, 1,  1, 32'h8000_0010, 0, 1, 32'h8000_000C, D3, 1);
        vecs[9]  = mk(0, 0,            0, 0, 0,  0, 0,  1, 32'h8000_0010, 0, 0, 0,            0,  0);
        vecs[10] = mk(1, 32'h8000_0002, 0, 0, 0,  0, 0,  0, 32'h8000_0010, 1, 0, 0,            0,  0);
        vecs[11] = mk(0, 0,            1, 0, 0,  0, 0,  1, 32'h8000_0000, 0, 0, 0,            0,  0);
        vecs[12] = mk(0, 0,            0, 1, D4, 0, 1,  1, 32'h8000_0004, 0, 0, 0,            0,  1);
        vecs[13] = mk(0, 0,            1, 0, 0,  0, 0,  1, 32'h8000_0004, 0, 1, 32'h8000_0002, D4, 1);
        vecs[14] = mk(0, 0,            0, 1, D5, 0, 0,  0, 32'h8000_0008, 0, 1, 32'h8000_0002, D4, 1);
        vecs[15] = mk(0, 0,            0, 0, 0,  0, 0,  0, 32'h8000_0008, 0, 1, 32'h8000_0002, D4, 1);
        vecs[16] = mk(0, 0,            0, 0, 0,  0, 1,  0, 32'h8000_0008, 0, 1, 32'h8000_0002, D4, 1);
        vecs[17] = mk(0, 0,            0, 0, 0,  0, 0,  1, 32'h8000_0008, 0, 1, 32'h8000_0004, D5, 1);
        vecs[18] = mk(0, 0,            0, 0, 0,  1, 1,  1, 32'h8000_0008, 0, 1, 32'h8000_0004, D5, 1);
        vecs[19] = mk(0, 0,            0, 0, 0,  0, 1,  1, 32'h8000_0008, 0, 1, 32'h8000_0004, D5, 1);
        vecs[20] = mk(0, 0,            0, 0, 0,  0, 0,  1, 32'h8000_0008, 0, 0, 0,            0,  0);

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all("reset", 0, 0, 0, 0, 0, 0, 0);
        advance();
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].rd, vecs[i].ra, vecs[i].gnt, vecs[i].rv, vecs[i].d, vecs[i].su, vecs[i].qr);
            @(negedge clk);
            check_all($sformatf("row%0d", i), vecs[i].e_req, vecs[i].e_ia, vecs[i].e_kill,
                      vecs[i].e_rv, vecs[i].e_ra, vecs[i].e_d, vecs[i].e_busy);
            advance();
        end

        // Redirect with two requests in flight: both late responses must be discarded.
        drive(0, 0, 1, 0, 0, 0, 0);
        @(negedge clk); check("kill_pre1 req", bus.icache_req_o, 1);
        advance();
        drive(0, 0, 1, 0, 0, 0, 0);
        @(negedge clk); check("kill_pre2 iaddr", bus.icache_addr_o, 32'h8000_000C);
        advance();
        drive(1, 32'h9000_0000, 1, 0, 0, 0, 0);
        @(negedge clk); check_all("kill_cyc", 0, 32'h8000_0010, 1, 0, 0, 0, 1);
        advance();
        drive(0, 0, 0, 1, 32'hBAD0_0001, 0, 0);
        @(negedge clk); check_all("kill_drop1", 1, 32'h9000_0000, 0, 0, 0, 0, 0);
        advance();
        drive(0, 0, 1, 1, 32'hBAD0_0002, 0, 0);
        @(negedge clk); check("kill_drop2 rv", bus.realign_valid_o, 0);
        advance();
        drive(0, 0, 0, 1, 32'h600D_0000, 0, 0);
        @(negedge clk); check("kill_good busy", bus.busy_o, 1);
        check("kill_good rv", bus.realign_valid_o, 0);
        advance();
        drive(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk); check_all("kill_head", 1, 32'h9000_0004, 0, 1, 32'h9000_0000, 32'h600D_0000, 1);
        advance();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); check("kill_after rv", bus.realign_valid_o, 0);
        check("kill_after busy", bus.busy_o, 0);
        advance();

        // Asynchronous reset while a request is outstanding.
        drive(0, 0, 1, 0, 0, 0, 0);
        advance();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("rst_pre busy", bus.busy_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("rst_mid", 0, 0, 0, 0, 0, 0, 0);
        advance();
        advance();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_all($sformatf("rst_idle%0d", i), 0, 0, 0, 0, 0, 0, 0);
            advance();
        end
        drive(1, 32'hA000_0006, 0, 0, 0, 0, 0);
        advance();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("rst_restart req", bus.icache_req_o, 1);
        check("rst_restart iaddr", bus.icache_addr_o, 32'hA000_0004);
        advance();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
